// File: rtl/delay_pkg.sv
// Shared types and width helpers for the delay bank and its per-channel delay engines.
package delay_pkg;

  typedef enum logic {
    DELAY_RISING,
    DELAY_PULSE
  } delay_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    FIRE,
    DONE
  } delay_state_e;

  // A single channel still needs a 1-bit address port.
  function automatic int addr_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  function automatic int delay_width(input int gamma_cycle_width);
    return $clog2(gamma_cycle_width);
  endfunction

  // One spare bit above the delay range, widened further if the pulse is unusually long.
  function automatic int count_width(input int gamma_cycle_width, input int pulse_width);
    int dw;
    int pw;
    dw = $clog2(gamma_cycle_width) + 1;
    pw = $clog2(pulse_width + 1);
    return (dw > pw) ? dw : pw;
  endfunction

endpackage

// File: rtl/delay_channel.sv
// One delay engine: an IDLE/COUNT/FIRE/DONE state machine with a shared delay/pulse counter.
module delay_channel
  import delay_pkg::*;
#(
  parameter int          GAMMA_CYCLE_WIDTH = 128,
  parameter int          PULSE_WIDTH       = 8,
  parameter delay_mode_e MODE              = DELAY_PULSE,
  localparam int         DW                = delay_width(GAMMA_CYCLE_WIDTH),
  localparam int         CW                = count_width(GAMMA_CYCLE_WIDTH, PULSE_WIDTH)
) (
  input  logic          aclk,
  input  logic          grst,
  input  logic          spike,
  input  logic [DW-1:0] load_delay,
  output logic          out,
  output logic          busy
);

  delay_state_e  state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] active_delay;

  // NOTE: state, counter and output all update with <= so every branch sees pre-edge values.
  always_ff @(posedge aclk) begin
    if (grst) begin
      state        <= IDLE;
      cnt          <= '0;
      out          <= 1'b0;
      active_delay <= load_delay;
    end else begin
      unique case (state)
        IDLE: begin
          if (spike) begin
            cnt <= CW'(1);
            if (active_delay == '0) begin
              state <= FIRE;
              out   <= 1'b1;
            end else begin
              state <= COUNT;
            end
          end
        end
        COUNT: begin
          if (cnt == CW'(active_delay)) begin
            // The counter restarts to time the pulse width.
            state <= FIRE;
            out   <= 1'b1;
            cnt   <= CW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIRE: begin
          if (MODE == DELAY_PULSE) begin
            if (cnt == CW'(PULSE_WIDTH)) begin
              state <= DONE;
              out   <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DONE: begin
          out <= 1'b0;
        end
        default: begin
          state <= IDLE;
          out   <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state == COUNT) || ((MODE == DELAY_PULSE) && (state == FIRE));

endmodule

// File: rtl/delay_bank.sv
// Array of programmable spike delays with double-buffered delay values applied at gamma reset.
module delay_bank
  import delay_pkg::*;
#(
  parameter int          N_CH              = 16,
  parameter int          GAMMA_CYCLE_WIDTH = 128,
  parameter int          PULSE_WIDTH       = 8,
  parameter delay_mode_e MODE              = DELAY_PULSE,
  localparam int         AW                = addr_width(N_CH),
  localparam int         DW                = delay_width(GAMMA_CYCLE_WIDTH)
) (
  input  logic            aclk,
  input  logic            grst,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] out,
  input  logic            delay_wr_en,
  input  logic [AW-1:0]   delay_wr_addr,
  input  logic [DW-1:0]   delay_wr_data,
  output logic            busy
);

  logic [N_CH-1:0] ch_busy;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic          wr_hit;
    logic [DW-1:0] shadow;
    logic [DW-1:0] load_delay;

    // Exact per-channel decode: addresses at or above N_CH match no channel.
    assign wr_hit = delay_wr_en && (delay_wr_addr == AW'(i));

    // NOTE: shadow delays are configuration, so they have no reset and survive grst.
    always_ff @(posedge aclk) begin
      if (wr_hit) begin
        shadow <= delay_wr_data;
      end
    end

    // A write landing in the reset cycle goes straight to the active delay.
    assign load_delay = wr_hit ? delay_wr_data : shadow;

    delay_channel #(
      .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH),
      .PULSE_WIDTH      (PULSE_WIDTH),
      .MODE             (MODE)
    ) u_channel (
      .aclk      (aclk),
      .grst      (grst),
      .spike     (in[i]),
      .load_delay(load_delay),
      .out       (out[i]),
      .busy      (ch_busy[i])
    );
  end

  assign busy = |ch_busy;

endmodule
